// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared defaults and types for the instruction-fetch front end.
// The fetch entry pairs a returned instruction word with the address it was read from.
package fetch_prefetch_queue_pkg;

    localparam int unsigned FETCH_ADDR_W = 11;
    localparam int unsigned FETCH_DATA_W = 32;
    localparam int unsigned FETCH_DEPTH  = 4;
    localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] data;
    } fetch_entry_t;

    function automatic int unsigned fetch_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus: redirect, decode handshake, program load and instruction memory port.
// master = fetch unit side, slave = core/memory environment side.
interface fetch_prefetch_queue_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
);
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst_data;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  load_wr;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;

    modport master (
        input  redirect_valid, redirect_pc, inst_ready,
        input  load_wr, load_addr, load_data, mem_rd_data,
        output inst_valid, inst_data, inst_pc,
        output mem_rd, mem_rd_addr, mem_wr, mem_wr_addr, mem_wr_data
    );

    modport slave (
        output redirect_valid, redirect_pc, inst_ready,
        output load_wr, load_addr, load_data, mem_rd_data,
        input  inst_valid, inst_data, inst_pc,
        input  mem_rd, mem_rd_addr, mem_wr, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/fetch_prefetch_queue_fifo.sv
// Synchronous circular FIFO holding {pc, data} prefetch entries.
// Flush empties the queue and wins over push/pop in the same cycle.
module fetch_prefetch_queue_fifo
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    parameter int WIDTH = FETCH_ADDR_W + FETCH_DATA_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = fetch_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the PC, issues sequential reads to a 1-cycle memory,
// buffers returned words in a prefetch queue, and handles redirect and program load.
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int                    ADDR_WIDTH = FETCH_ADDR_W,
    parameter int                    DATA_WIDTH = FETCH_DATA_W,
    parameter int                    DEPTH      = FETCH_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_prefetch_queue_if.master bus
);

    localparam int CNT_W = fetch_cnt_w(DEPTH);
    localparam int SUM_W = CNT_W + 1;
    localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_inflight_pc;

    logic [CNT_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_empty;
    logic [ENT_W-1:0]      w_head;
    logic [SUM_W-1:0]      w_outstanding;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;

    // Credit counts queued plus in-flight words so a return always finds a free slot,
    // and deliberately ignores inst_ready to keep decode off the memory address path.
    assign w_outstanding = SUM_W'(w_count) + SUM_W'(r_inflight);
    assign w_issue = rst_n & ~bus.load_wr & ~bus.redirect_valid
                   & (w_outstanding < SUM_W'(DEPTH));
    assign w_push  = r_inflight & ~bus.redirect_valid & ~w_full;
    assign w_pop   = ~w_empty & bus.inst_ready;

    fetch_prefetch_queue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_wdata ({r_inflight_pc, bus.mem_rd_data}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.inst_valid  = ~w_empty;
    assign bus.inst_pc     = w_empty ? '0 : w_head[ENT_W-1:DATA_WIDTH];
    assign bus.inst_data   = w_empty ? '0 : w_head[DATA_WIDTH-1:0];

    assign bus.mem_rd      = w_issue;
    assign bus.mem_rd_addr = w_issue ? r_fetch_pc : '0;

    assign bus.mem_wr      = rst_n & bus.load_wr;
    assign bus.mem_wr_addr = bus.mem_wr ? bus.load_addr : '0;
    assign bus.mem_wr_data = bus.mem_wr ? bus.load_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) r_inflight_pc <= r_fetch_pc;
            if (bus.redirect_valid) begin
                r_fetch_pc <= bus.redirect_pc;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 1'b1;
            end
        end
    end

endmodule
